coherence_control: RTL and testbench

COHERENCE_CONTROL -- requirements
Module: coherence_control

---
 rtl/coherence_control.sv | 210 +++++++++++++++++++++
 tb/tb_coherence_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_control.sv
// Two-core MSI bus coherence controller: arbitrates icache/dcache requests onto one RAM port.
// Ports: CLK/nRST; per-core i*/d*/cc* cache links; ram* memory port. Macro: CACHE_TO_CACHE_EN.
module coherence_control #(
   parameter int CPUS = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [CPUS-1:0]       iREN,
   input  logic [CPUS-1:0][31:0] iaddr,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0][31:0] iload,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]       dwait,
   output logic [CPUS-1:0][31:0] dload,
   input  logic [CPUS-1:0]       cctrans,
   input  logic [CPUS-1:0]       ccwrite,
   output logic [CPUS-1:0]       ccwait,
   output logic [CPUS-1:0]       ccinv,
   output logic [CPUS-1:0][31:0] ccsnoopaddr,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [31:0]           ramaddr,
   output logic [31:0]           ramstore,
   input  logic [31:0]           ramload,
   input  logic [1:0]            ramstate
);

   typedef enum logic [3:0] {
      IDLE, SNOOP, WB0, WB1, FILL0, FILL1,
      C2C0, C2C1, INVAL, IFETCH
   } state_t;

   localparam logic [1:0] ACCESS = 2'd2;

   state_t state, state_n;
   logic   req, req_n;
   logic   dptr, dptr_n;
   logic   iptr, iptr_n;
   logic   fil, fil_n;
   logic   inv, inv_n;
   logic   snp, snp_n;
   logic   acc, oth, wbc, g;
   logic [CPUS-1:0] fill_v, upg_v;

   function automatic logic pick(
      input logic [CPUS-1:0] v,
      input logic            p
   );
      return v[p] ? p : ~p;
   endfunction

   assign acc    = (ramstate == ACCESS);
   assign oth    = ~req;
   // fil: this transaction is a fill, so the other core stays frozen
   // snp: write-back phase runs on behalf of the snooped core
   assign wbc    = snp ? oth : req;
   assign fill_v = dREN & cctrans;
   assign upg_v  = cctrans & ~dREN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         req   <= 1'b0;
         dptr  <= 1'b0;
         iptr  <= 1'b0;
         fil   <= 1'b0;
         inv   <= 1'b0;
         snp   <= 1'b0;
      end else begin
         state <= state_n;
         req   <= req_n;
         dptr  <= dptr_n;
         iptr  <= iptr_n;
         fil   <= fil_n;
         inv   <= inv_n;
         snp   <= snp_n;
      end
   end

   always_comb begin
      state_n = state;
      req_n   = req;
      dptr_n  = dptr;
      iptr_n  = iptr;
      fil_n   = fil;
      inv_n   = inv;
      snp_n   = snp;
      g       = 1'b0;
      unique case (state)
         IDLE: begin
            fil_n = 1'b0;
            inv_n = 1'b0;
            snp_n = 1'b0;
            if (|dWEN) begin
               g       = pick(dWEN, dptr);
               req_n   = g;
               dptr_n  = ~dptr;
               state_n = WB0;
            end else if (|fill_v) begin
               g       = pick(fill_v, dptr);
               req_n   = g;
               dptr_n  = ~dptr;
               fil_n   = 1'b1;
               inv_n   = ccwrite[g];
               state_n = SNOOP;
            end else if (|upg_v) begin
               g       = pick(upg_v, dptr);
               req_n   = g;
               dptr_n  = ~dptr;
               state_n = INVAL;
            end else if (|iREN) begin
               g       = pick(iREN, iptr);
               req_n   = g;
               iptr_n  = ~iptr;
               state_n = IFETCH;
            end
         end
         SNOOP: begin
`ifdef CACHE_TO_CACHE_EN
            if (cctrans[oth] && ccwrite[oth])
               state_n = C2C0;
            else
               state_n = FILL0;
`else
            // dirty hit: flush the owner first, then refill
            if (cctrans[oth] && ccwrite[oth]) begin
               state_n = WB0;
               snp_n   = 1'b1;
            end else begin
               state_n = FILL0;
            end
`endif
         end
         WB0:    if (acc) state_n = WB1;
         WB1:    if (acc) state_n = snp ? FILL0 : IDLE;
         FILL0:  if (acc) state_n = FILL1;
         FILL1:  if (acc) state_n = IDLE;
`ifdef CACHE_TO_CACHE_EN
         C2C0:   if (acc) state_n = C2C1;
         C2C1:   if (acc) state_n = IDLE;
`else
         C2C0, C2C1: state_n = IDLE;
`endif
         INVAL:  state_n = IDLE;
         IFETCH: if (acc) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      // fill holds the other core frozen until back in IDLE
      if (fil && state != IDLE) begin
         ccwait[oth]      = 1'b1;
         ccinv[oth]       = inv;
         ccsnoopaddr[oth] = daddr[req];
      end
      unique case (state)
         WB0, WB1: begin
            ramWEN     = 1'b1;
            ramaddr    = daddr[wbc];
            ramstore   = dstore[wbc];
            dwait[wbc] = ~acc;
         end
         FILL0, FILL1: begin
            ramREN     = 1'b1;
            ramaddr    = daddr[req];
            dload[req] = ramload;
            dwait[req] = ~acc;
         end
`ifdef CACHE_TO_CACHE_EN
         C2C0, C2C1: begin
            ramWEN     = 1'b1;
            ramaddr    = daddr[oth];
            ramstore   = dstore[oth];
            dload[req] = dstore[oth];
            dwait[req] = ~acc;
            dwait[oth] = ~acc;
         end
`endif
         INVAL: begin
            ccwait[oth]      = 1'b1;
            ccinv[oth]       = 1'b1;
            ccsnoopaddr[oth] = daddr[req];
            dwait[req]       = 1'b0;
         end
         IFETCH: begin
            ramREN     = 1'b1;
            ramaddr    = iaddr[req];
            iload[req] = ramload;
            iwait[req] = ~acc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_coherence_control.sv
// Scoreboard bench for coherence_control with a latency-configurable RAM.
// Expected cache events and RAM writes are queued at stimulus time and popped as they occur.
module tb_coherence_control;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [1:0]        iREN, dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0]  iaddr, daddr, dstore;
   logic [1:0]        iwait, dwait, ccwait, ccinv;
   logic [1:0][31:0]  iload, dload, ccsnoopaddr;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   coherence_control #(.CPUS(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait),
      .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // RAM: lat BUSY cycles, then one ACCESS cycle per word
   logic [31:0] mem [0:1023];
   int lat = 2;
   int cnt;
   assign ramload  = mem[ramaddr[11:2]];
   assign ramstate = (ramREN || ramWEN) ?
                     ((cnt >= lat) ? 2'd2 : 2'd1) : 2'd0;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) cnt <= 0;
      else if ((ramREN || ramWEN) && cnt < lat) cnt <= cnt + 1;
      else cnt <= 0;
   end

   always @(posedge CLK)
      if (ramWEN && ramstate == 2'd2)
         mem[ramaddr[11:2]] <= ramstore;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // code = {dcache, core}
   typedef struct packed {
      logic [1:0]  code;
      logic [31:0] data;
   } ev_t;
   ev_t         oq[$];
   logic [63:0] wq[$];

   task automatic exp_ev(input logic [1:0] code, input logic [31:0] d);
      ev_t e;
      e.code = code;
      e.data = d;
      oq.push_back(e);
   endtask

   task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
      wq.push_back({a, d});
   endtask

   task automatic pop_ev(input logic [1:0] code, input logic [31:0] d);
      ev_t e;
      if (oq.size() == 0) begin
         check("unexp_ev", 64'({code, d}), 64'h3_FFFF_FFFF);
      end else begin
         e = oq.pop_front();
         check("ev", 64'({code, d}), 64'({e.code, e.data}));
      end
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         if (!iwait[0]) pop_ev(2'b00, iload[0]);
         if (!iwait[1]) pop_ev(2'b01, iload[1]);
         if (!dwait[0]) pop_ev(2'b10, dload[0]);
         if (!dwait[1]) pop_ev(2'b11, dload[1]);
         if (ramWEN && ramstate == 2'd2) begin
            if (wq.size() == 0)
               check("unexp_wr", {ramaddr, ramstore}, '1);
            else
               check("ramwr", {ramaddr, ramstore}, wq.pop_front());
         end
      end
   end

   task automatic sb_empty(input string tag);
      repeat (3) @(negedge CLK);
      check(tag, 64'(oq.size() + wq.size()), 64'(0));
      oq.delete();
      wq.delete();
   endtask

   task automatic wait_snoop(input int c);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 60 && !hit; k++) begin
         @(negedge CLK);
         if (ccwait[c]) hit = 1'b1;
      end
      check("snoop_seen", 64'(hit), 64'(1));
   endtask

   // completes dcache words; each done word advances that core
   task automatic serve(input int n0, input int n1,
                        input logic [31:0] t0,
                        input logic [31:0] t1);
      int c0, c1;
      logic [1:0] lo;
      c0 = 0;
      c1 = 0;
      for (int k = 0; k < 300 && (c0 < n0 || c1 < n1); k++) begin
         @(negedge CLK);
         lo = ~dwait;
         @(posedge CLK);
         #1;
         if (lo[0]) begin
            c0++;
            daddr[0] += 32'd4;
            dstore[0] = t0;
         end
         if (lo[1]) begin
            c1++;
            daddr[1] += 32'd4;
            dstore[1] = t1;
         end
         if (c0 >= n0) begin
            dREN[0] = 0; dWEN[0] = 0;
            cctrans[0] = 0; ccwrite[0] = 0;
         end
         if (c1 >= n1) begin
            dREN[1] = 0; dWEN[1] = 0;
            cctrans[1] = 0; ccwrite[1] = 0;
         end
      end
      check("serve_done", 64'(c0 >= n0 && c1 >= n1), 64'(1));
   endtask

   int ni, nd;
   logic [1:0] li, ld;

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] = 32'h1000_0000 | (i << 2);
      nRST = 0;
      iREN = 0; dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
      iaddr = '0; daddr = '0; dstore = '0;

      // reset defaults
      @(negedge CLK);
      check("rst_iwait", 64'(iwait), 64'(2'b11));
      check("rst_dwait", 64'(dwait), 64'(2'b11));
      check("rst_ccwait", 64'(ccwait), 64'(0));
      check("rst_ccinv", 64'(ccinv), 64'(0));
      check("rst_ram", 64'({ramREN, ramWEN}), 64'(0));
      check("rst_ramaddr", 64'(ramaddr), 64'(0));
      @(posedge CLK);
      #1 nRST = 1;

      // write-back, 2 BUSY then ACCESS per word
      exp_ev(2'b10, 32'h0); exp_ev(2'b10, 32'h0);
      exp_w(32'h100, 32'hAAAA); exp_w(32'h104, 32'hBBBB);
      daddr[0] = 32'h100; dstore[0] = 32'hAAAA; dWEN[0] = 1;
      serve(2, 0, 32'hBBBB, 32'h0);
      sb_empty("wb_sb");

      // clean miss by core 1
      exp_ev(2'b11, 32'h1000_0200); exp_ev(2'b11, 32'h1000_0204);
      daddr[1] = 32'h200; dREN[1] = 1; cctrans[1] = 1; ccwrite[1] = 0;
      wait_snoop(0);
      check("snp_addr", 64'(ccsnoopaddr[0]), 64'h200);
      check("snp_inv", 64'(ccinv[0]), 64'(0));
      check("snp_noram", 64'({ramREN, ramWEN}), 64'(0));
      @(negedge CLK);
      check("fill_ren", 64'(ramREN), 64'(1));
      serve(0, 2, 32'h0, 32'h0);
      sb_empty("miss_sb");

      // dirty miss: core 0 holds 0x300 Modified
`ifdef CACHE_TO_CACHE_EN
      exp_ev(2'b10, 32'h0); exp_ev(2'b11, 32'hDEAD);
      exp_ev(2'b10, 32'h0); exp_ev(2'b11, 32'hBEEF);
`else
      exp_ev(2'b10, 32'h0); exp_ev(2'b10, 32'h0);
      exp_ev(2'b11, 32'hDEAD); exp_ev(2'b11, 32'hBEEF);
`endif
      exp_w(32'h300, 32'hDEAD); exp_w(32'h304, 32'hBEEF);
      daddr[0] = 32'h300; dstore[0] = 32'hDEAD;
      daddr[1] = 32'h300; dREN[1] = 1; cctrans[1] = 1; ccwrite[1] = 1;
      wait_snoop(0);
      check("dirty_inv", 64'(ccinv[0]), 64'(1));
      check("dirty_addr", 64'(ccsnoopaddr[0]), 64'h300);
      cctrans[0] = 1; ccwrite[0] = 1;
      serve(2, 2, 32'hBEEF, 32'h0);
      sb_empty("dirty_sb");

      // upgrade by core 0
      exp_ev(2'b10, 32'h0);
      daddr[0] = 32'h400; cctrans[0] = 1;
      wait_snoop(1);
      check("upg_inv", 64'(ccinv[1]), 64'(1));
      check("upg_addr", 64'(ccsnoopaddr[1]), 64'h400);
      check("upg_noram", 64'({ramREN, ramWEN}), 64'(0));
      @(posedge CLK);
      #1 cctrans[0] = 0;
      @(negedge CLK);
      check("upg_1cyc", 64'(ccwait[1]), 64'(0));
      sb_empty("upg_sb");

      // reset pulsed in FILL0
      lat = 20;
      daddr[1] = 32'h200; dREN[1] = 1; cctrans[1] = 1; ccwrite[1] = 1;
      wait_snoop(0);
      @(negedge CLK);
      check("f0_ren", 64'(ramREN), 64'(1));
      nRST = 0;
      #1;
      check("mid_ram", 64'({ramREN, ramWEN}), 64'(0));
      check("mid_dwait", 64'(dwait), 64'(2'b11));
      check("mid_cc", 64'({ccwait, ccinv}), 64'(0));
      check("mid_addr", 64'(ramaddr), 64'(0));
      dREN = 0; cctrans = 0; ccwrite = 0;
      @(negedge CLK);
      nRST = 1;
      lat = 2;
      @(negedge CLK);
      check("post_idle", 64'({ramREN, ramWEN, ccwait}), 64'(0));

      // icache contention, then a write-back cutting in
      iaddr[0] = 32'h500; iaddr[1] = 32'h600;
      exp_ev(2'b00, 32'h1000_0500); exp_ev(2'b01, 32'h1000_0600);
      exp_ev(2'b00, 32'h1000_0500);
      exp_ev(2'b11, 32'h0); exp_ev(2'b11, 32'h0);
      exp_ev(2'b01, 32'h1000_0600); exp_ev(2'b00, 32'h1000_0500);
      exp_w(32'h700, 32'h77); exp_w(32'h704, 32'h78);
      iREN = 2'b11;
      ni = 0;
      nd = 0;
      for (int k = 0; k < 400 && ni < 5; k++) begin
         @(negedge CLK);
         li = ~iwait;
         ld = ~dwait;
         @(posedge CLK);
         #1;
         if (|li) ni++;
         if (ld[1]) begin
            nd++;
            daddr[1] += 32'd4;
            dstore[1] = 32'h78;
            if (nd == 2) dWEN[1] = 0;
         end
         if (ni == 3 && nd == 0 && !dWEN[1]) begin
            dWEN[1] = 1; daddr[1] = 32'h700; dstore[1] = 32'h77;
         end
         if (ni == 5) iREN = 0;
      end
      check("ifetch_done", 64'(ni), 64'(5));
      sb_empty("cont_sb");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
